// File: rtl/store_narrow_unit_if.sv
// Store-path bus bundle between the MEM stage and data memory.
// Pipeline side: st_valid/st_ready/st_addr/st_data/st_size/st_done/st_err/busy.
// Memory side:   mem_req/mem_addr/mem_wdata/mem_be/mem_ack.
// slave  : view of the store unit itself.
// master : view of the pipeline plus memory environment driving the unit.
interface store_narrow_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              st_done;
  logic [1:0]        st_err;
  logic              busy;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err, busy
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err, busy
  );
endinterface

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: narrows a 32-bit register value to byte/half/word,
// replicates it across the byte lanes of a word-aligned write, drives byte
// enables, and runs a req/ack handshake with data memory including a
// misalignment check and a bus timeout.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - store_narrow_unit_if.slave (pipeline request/completion and
//           memory write channel)
module store_narrow_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  store_narrow_unit_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  // Counter value seen during the last permitted REQ cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ready_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              done_q;
  logic [1:0]        err_q, err_d;
  logic              busy_q;

  // Lane placement of the incoming request (only consumed at acceptance).
  logic [1:0]        lane_off;
  logic              lane_legal;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;

  // Narrowing, lane replication and alignment check.
  always_comb begin
    lane_off   = bus.st_addr[1:0];
    lane_legal = 1'b0;
    lane_be    = 4'b0000;
    lane_wdata = bus.st_data;
    case (bus.st_size)
      SZ_BYTE: begin
        lane_legal = 1'b1;
        lane_be    = 4'b0001 << lane_off;
        lane_wdata = {4{bus.st_data[7:0]}};
      end
      SZ_HALF: begin
        lane_legal = ~lane_off[0];
        lane_be    = lane_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{bus.st_data[15:0]}};
      end
      SZ_WORD: begin
        lane_legal = (lane_off == 2'b00);
        lane_be    = 4'b1111;
        lane_wdata = bus.st_data;
      end
      default: begin
        lane_legal = 1'b0;
      end
    endcase
    // A rejected store never enables any lane.
    if (!lane_legal) begin
      lane_be = 4'b0000;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = ERR_OK;

    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          addr_d  = {bus.st_addr[ADDR_W-1:2], 2'b00};
          wdata_d = lane_wdata;
          be_d    = lane_be;
          cnt_d   = '0;
          if (lane_legal) begin
            state_d = REQ;
          end else begin
            state_d = RESP;
            err_d   = ERR_ALIGN;
          end
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (bus.mem_ack) begin
          state_d = RESP;
          err_d   = ERR_OK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = RESP;
            err_d   = ERR_TMO;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      req_q   <= (state_d == REQ);
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= (state_d == RESP);
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.st_ready  = ready_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.st_done   = done_q;
  assign bus.st_err    = err_q;
  assign bus.busy      = busy_q;

endmodule
